// File: rtl/led_display_package.sv
// Shared types and constants for the LED panel display path: row data layout,
// panel geometry and the row driver state encoding.
package led_display_package;

    localparam int GL_PANEL_ROW_PIXELS = 32;
    localparam int GL_PANEL_ADDR_W     = 4;
    localparam int GL_PIX_IDX_W        = $clog2(GL_PANEL_ROW_PIXELS);

    typedef struct packed {
        logic [GL_PANEL_ROW_PIXELS-1:0] red;
        logic [GL_PANEL_ROW_PIXELS-1:0] green;
        logic [GL_PANEL_ROW_PIXELS-1:0] blue;
    } rgb_plane_t;

    typedef struct packed {
        rgb_plane_t top;
        rgb_plane_t bot;
    } rgb_row_t;

    localparam int GL_RGB_ROW_W = $bits(rgb_row_t);

    typedef enum logic [2:0] {
        DRV_IDLE,
        DRV_SHIFT,
        DRV_BLANK,
        DRV_LATCH,
        DRV_DISPLAY
    } drv_state_t;

    // Panel data lines carry {B,G,R} for one column of one half.
    function automatic logic [2:0] pixel_bgr(input rgb_plane_t plane,
                                             input logic [GL_PIX_IDX_W-1:0] col);
        return {plane.blue[col], plane.green[col], plane.red[col]};
    endfunction

endpackage

// File: rtl/led_display_shift_clk_gen.sv
// Shift-clock phase generator: low for CLK_DIV cycles then high for CLK_DIV
// cycles per pixel, with a strobe on the last phase to advance the pixel.
module led_display_shift_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_in,
    input  logic n_reset_in,
    input  logic run_in,
    output logic shift_clk_out,
    output logic pixel_adv_out
);

    localparam int PHASES = 2 * CLK_DIV;
    localparam int PH_W   = $clog2(PHASES);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASES - 1);
    localparam logic [PH_W-1:0] PH_HIGH = PH_W'(CLK_DIV);

    logic [PH_W-1:0] phase_reg;
    logic [PH_W-1:0] phase_next;
    logic            shift_clk_reg;

    // Phase rests at 0 whenever the row is not shifting, so every row starts low.
    always_comb begin
        phase_next = '0;
        if (run_in && (phase_reg != PH_LAST)) begin
            phase_next = phase_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            phase_reg     <= '0;
            shift_clk_reg <= 1'b0;
        end else begin
            phase_reg     <= phase_next;
            shift_clk_reg <= (phase_next >= PH_HIGH);
        end
    end

    assign shift_clk_out = shift_clk_reg;
    assign pixel_adv_out = run_in && (phase_reg == PH_LAST);

endmodule

// File: rtl/led_display_row_driver.sv
// HUB75 row driver: accepts one row over valid/ready, shifts it out MSB column
// first, then blanks, latches and lights the row before asking for the next.
module led_display_row_driver
    import led_display_package::*;
#(
    parameter int CLK_DIV      = 2,
    parameter int BLANK_CYCLES = 2,
    parameter int ON_CYCLES    = 64,
    parameter int ROW_PIXELS   = GL_PANEL_ROW_PIXELS
) (
    input  logic                       clk_in,
    input  logic                       n_reset_in,
    input  logic [GL_RGB_ROW_W-1:0]    row_in,
    input  logic                       row_valid_in,
    input  logic [GL_PANEL_ADDR_W-1:0] row_address_in,
    output logic                       row_ready_out,
    output logic [2:0]                 panel_rgb_top_out,
    output logic [2:0]                 panel_rgb_bot_out,
    output logic                       panel_clk_out,
    output logic                       panel_lat_out,
    output logic                       panel_oe_n_out,
    output logic [GL_PANEL_ADDR_W-1:0] panel_addr_out,
    output logic                       row_done_out
);

    localparam int PIX_W   = $clog2(ROW_PIXELS);
    localparam int CNT_MAX = (BLANK_CYCLES > ON_CYCLES) ? BLANK_CYCLES : ON_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [PIX_W-1:0] PIX_FIRST  = PIX_W'(ROW_PIXELS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);

    drv_state_t                 state_reg, state_next;
    logic [PIX_W-1:0]           pix_reg, pix_next;
    logic [CNT_W-1:0]           cnt_reg, cnt_next;
    rgb_row_t                   row_reg;
    logic [GL_PANEL_ADDR_W-1:0] addr_cap_reg;

    logic                       ready_reg;
    logic [2:0]                 top_reg, bot_reg;
    logic                       lat_reg, oe_n_reg, done_reg;
    logic [GL_PANEL_ADDR_W-1:0] addr_reg;

    logic                       accept;
    logic                       shift_run;
    logic                       pixel_adv;
    logic                       shift_clk;
    rgb_row_t                   pix_src;

    assign accept    = (state_reg == DRV_IDLE) && ready_reg && row_valid_in;
    assign shift_run = (state_reg == DRV_SHIFT);
    // The first pixel is taken straight from the input on the accept edge.
    assign pix_src   = accept ? rgb_row_t'(row_in) : row_reg;

    led_display_shift_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_shift_clk_gen (
        .clk_in        (clk_in),
        .n_reset_in    (n_reset_in),
        .run_in        (shift_run),
        .shift_clk_out (shift_clk),
        .pixel_adv_out (pixel_adv)
    );

    always_comb begin
        state_next = state_reg;
        pix_next   = pix_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            DRV_IDLE: begin
                if (accept) begin
                    state_next = DRV_SHIFT;
                    pix_next   = PIX_FIRST;
                end
            end
            DRV_SHIFT: begin
                if (pixel_adv) begin
                    if (pix_reg == '0) begin
                        state_next = DRV_BLANK;
                        cnt_next   = BLANK_LAST;
                    end else begin
                        pix_next = pix_reg - 1'b1;
                    end
                end
            end
            DRV_BLANK: begin
                if (cnt_reg == '0) begin
                    state_next = DRV_LATCH;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DRV_LATCH: begin
                state_next = DRV_DISPLAY;
                cnt_next   = ON_LAST;
            end
            DRV_DISPLAY: begin
                if (cnt_reg == '0) begin
                    state_next = DRV_IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = DRV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_reg    <= DRV_IDLE;
            pix_reg      <= '0;
            cnt_reg      <= '0;
            row_reg      <= '0;
            addr_cap_reg <= '0;
        end else begin
            state_reg <= state_next;
            pix_reg   <= pix_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                row_reg      <= rgb_row_t'(row_in);
                addr_cap_reg <= row_address_in;
            end
        end
    end

    // Outputs are registered from next-state values so they line up with the state.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            ready_reg <= 1'b0;
            top_reg   <= '0;
            bot_reg   <= '0;
            lat_reg   <= 1'b0;
            oe_n_reg  <= 1'b1;
            addr_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            ready_reg <= (state_next == DRV_IDLE);
            lat_reg   <= (state_next == DRV_LATCH);
            oe_n_reg  <= (state_next != DRV_DISPLAY);
            done_reg  <= (state_next == DRV_DISPLAY) && (cnt_next == '0);
            if (state_next != DRV_SHIFT) begin
                top_reg <= '0;
                bot_reg <= '0;
            end else if (accept || pixel_adv) begin
                top_reg <= pixel_bgr(pix_src.top, pix_next);
                bot_reg <= pixel_bgr(pix_src.bot, pix_next);
            end
            if (shift_run && (state_next == DRV_BLANK)) begin
                addr_reg <= addr_cap_reg;
            end
        end
    end

    assign row_ready_out     = ready_reg;
    assign panel_rgb_top_out = top_reg;
    assign panel_rgb_bot_out = bot_reg;
    assign panel_clk_out     = shift_clk;
    assign panel_lat_out     = lat_reg;
    assign panel_oe_n_out    = oe_n_reg;
    assign panel_addr_out    = addr_reg;
    assign row_done_out      = done_reg;

endmodule

// File: tb/tb_led_display_row_driver.sv
// Bench for led_display_row_driver: three parameterisations driven with the
// same stimulus, each compared every cycle against a timeline model of a row.
`timescale 1ns/1ps
module tb_led_display_row_driver;
    import led_display_package::*;

    localparam int NDUT = 3;

    function automatic int cd_of(input int i);
        return (i == 1) ? 2 : 1;
    endfunction
    function automatic int bl_of(input int i);
        return (i == 2) ? 1 : 2;
    endfunction
    function automatic int on_of(input int i);
        return (i == 0) ? 8 : ((i == 1) ? 64 : 1);
    endfunction
    // Hand-computed row periods: 1+64+2+1+8, 1+128+2+1+64, 1+64+1+1+1.
    function automatic int per_lit(input int i);
        return (i == 0) ? 76 : ((i == 1) ? 196 : 68);
    endfunction

    logic     clk_in = 1'b0;
    logic     n_reset_in = 1'b1;
    rgb_row_t row_in;
    logic     row_valid_in;
    logic [3:0] row_address_in;

    logic       ready_o [NDUT];
    logic [2:0] top_o   [NDUT];
    logic [2:0] bot_o   [NDUT];
    logic       clk_o   [NDUT];
    logic       lat_o   [NDUT];
    logic       oe_o    [NDUT];
    logic [3:0] addr_o  [NDUT];
    logic       done_o  [NDUT];

    always #5 clk_in = ~clk_in;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        led_display_row_driver #(
            .CLK_DIV      (cd_of(gi)),
            .BLANK_CYCLES (bl_of(gi)),
            .ON_CYCLES    (on_of(gi)),
            .ROW_PIXELS   (32)
        ) u_dut (
            .clk_in            (clk_in),
            .n_reset_in        (n_reset_in),
            .row_in            (row_in),
            .row_valid_in      (row_valid_in),
            .row_address_in    (row_address_in),
            .row_ready_out     (ready_o[gi]),
            .panel_rgb_top_out (top_o[gi]),
            .panel_rgb_bot_out (bot_o[gi]),
            .panel_clk_out     (clk_o[gi]),
            .panel_lat_out     (lat_o[gi]),
            .panel_oe_n_out    (oe_o[gi]),
            .panel_addr_out    (addr_o[gi]),
            .row_done_out      (done_o[gi])
        );
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    rgb_row_t pat_a, pat_b;

    // Model state: one row in flight per DUT, described by its acceptance cycle.
    bit         m_busy      [NDUT];
    int         m_t0        [NDUT];
    rgb_row_t   m_row       [NDUT];
    logic [3:0] m_addr      [NDUT];
    logic [3:0] m_last_addr [NDUT];
    bit         m_ready_ok  [NDUT];
    int         m_kind      [NDUT];

    bit          trk_on     [NDUT];
    int          n_edge     [NDUT];
    int          n_oe       [NDUT];
    int          n_lat      [NDUT];
    int          n_done     [NDUT];
    logic [31:0] rmask      [NDUT];
    logic [31:0] bmask      [NDUT];
    bit          topany     [NDUT];
    logic        prev_clk   [NDUT];
    logic        prev_ready [NDUT];

    function automatic int period_of(input int i);
        return 1 + 32 * 2 * cd_of(i) + bl_of(i) + 1 + on_of(i);
    endfunction

    // Expected {ready, top, bot, clk, lat, oe_n, addr, done} for the current cycle.
    function automatic logic [14:0] predict(input int i);
        int k, s, j, pix, p, cd, bl, on;
        logic rdy, ck, lt, oen, dn;
        logic [2:0] t, b;
        logic [3:0] ad;
        cd = cd_of(i); bl = bl_of(i); on = on_of(i);
        s = 32 * 2 * cd;
        rdy = 1'b0; ck = 1'b0; lt = 1'b0; oen = 1'b1; dn = 1'b0;
        t = '0; b = '0; ad = m_last_addr[i];
        if (!m_busy[i]) begin
            rdy = m_ready_ok[i];
        end else begin
            k = cyc - m_t0[i];
            if (k <= s) begin
                j   = k - 1;
                pix = 31 - j / (2 * cd);
                p   = j % (2 * cd);
                ck  = (p >= cd);
                t = {m_row[i].top.blue[pix], m_row[i].top.green[pix], m_row[i].top.red[pix]};
                b = {m_row[i].bot.blue[pix], m_row[i].bot.green[pix], m_row[i].bot.red[pix]};
            end else begin
                ad = m_addr[i];
                if (k == s + bl + 1) begin
                    lt = 1'b1;
                end else if (k > s + bl + 1) begin
                    oen = 1'b0;
                    dn  = (k == s + bl + 1 + on);
                end
            end
        end
        return {rdy, t, b, ck, lt, oen, ad, dn};
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s dut%0d cycle %0d: got %0h want %0h", name, i, cyc, got, want);
        end
    endtask

    initial begin : compare
        logic is_clk;
        logic [14:0] act, exp_v;
        forever begin
            @(negedge clk_in or negedge n_reset_in);
            is_clk = !clk_in;
            #1;
            for (int i = 0; i < NDUT; i++) begin
                act = {ready_o[i], top_o[i], bot_o[i], clk_o[i], lat_o[i], oe_o[i],
                       addr_o[i], done_o[i]};
                if (!n_reset_in) begin
                    if (is_clk) chk("reset_state", i, {17'd0, act}, 32'h0020);
                    else        chk("async_reset", i, {17'd0, act}, 32'h0020);
                    m_busy[i] = 1'b0; m_ready_ok[i] = 1'b0; m_last_addr[i] = '0;
                    trk_on[i] = 1'b0; prev_clk[i] = 1'b0; prev_ready[i] = 1'b0;
                end else if (is_clk) begin
                    if (m_busy[i] && (cyc - m_t0[i] >= period_of(i))) begin
                        m_busy[i] = 1'b0;
                        m_last_addr[i] = m_addr[i];
                    end
                    exp_v = predict(i);
                    chk("outputs", i, {17'd0, act}, {17'd0, exp_v});
                    if (trk_on[i]) begin
                        if (!prev_clk[i] && clk_o[i]) begin
                            if (n_edge[i] < 32) begin
                                if (top_o[i] == 3'b001) rmask[i][n_edge[i]] = 1'b1;
                                if (bot_o[i] == 3'b010) bmask[i][n_edge[i]] = 1'b1;
                            end
                            n_edge[i]++;
                        end
                        if (top_o[i] != 3'b000) topany[i] = 1'b1;
                        if (!oe_o[i]) n_oe[i]++;
                        if (lat_o[i]) n_lat[i]++;
                        if (done_o[i]) n_done[i]++;
                        if (!prev_ready[i] && ready_o[i]) begin
                            chk("clk_edges", i, n_edge[i], 32);
                            chk("oe_low_cycles", i, n_oe[i], on_of(i));
                            chk("lat_cycles", i, n_lat[i], 1);
                            chk("done_pulses", i, n_done[i], 1);
                            chk("row_period", i, cyc - m_t0[i], per_lit(i));
                            if (m_kind[i] == 1) chk("top_red_edges", i, rmask[i], 32'h8000_0001);
                            if (m_kind[i] == 2) begin
                                chk("bot_green_edges", i, bmask[i], 32'hFFFF_FFFF);
                                chk("top_quiet", i, {31'd0, topany[i]}, 32'd0);
                            end
                            trk_on[i] = 1'b0;
                        end
                    end
                    prev_clk[i]   = clk_o[i];
                    prev_ready[i] = ready_o[i];
                    if (exp_v[14] && row_valid_in) begin
                        m_busy[i] = 1'b1;
                        m_t0[i]   = cyc;
                        m_row[i]  = row_in;
                        m_addr[i] = row_address_in;
                        m_kind[i] = (row_in == pat_a) ? 1 : ((row_in == pat_b) ? 2 : 0);
                        trk_on[i] = 1'b1;
                        n_edge[i] = 0; n_oe[i] = 0; n_lat[i] = 0; n_done[i] = 0;
                        rmask[i] = '0; bmask[i] = '0; topany[i] = 1'b0;
                    end
                    m_ready_ok[i] = 1'b1;
                end
            end
            if (is_clk) cyc++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    function automatic rgb_row_t rand_row();
        rgb_row_t r;
        for (int w = 0; w < GL_RGB_ROW_W / 32; w++) r[w*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic send(input rgb_row_t r, input logic [3:0] a);
        row_in = r;
        row_address_in = a;
        row_valid_in = 1'b1;
        tick(1);
        row_valid_in = 1'b0;
    endtask

    initial begin : stim
        pat_a = '0; pat_a.top.red   = 32'h8000_0001;
        pat_b = '0; pat_b.bot.green = 32'hFFFF_FFFF;
        row_in = '0; row_valid_in = 1'b0; row_address_in = '0;
        #7 n_reset_in = 1'b0;
        tick(3);
        n_reset_in = 1'b1;
        tick(1);
        send(pat_a, 4'd5);
        tick(250);
        // Bottom-plane row, with a valid pulse for address 9 while shifting.
        send(pat_b, 4'd3);
        tick(10);
        send(rand_row(), 4'd9);
        tick(250);
        // Back-to-back: valid held high with fresh random data every cycle.
        row_valid_in = 1'b1;
        repeat (700) begin
            row_in = rand_row();
            row_address_in = 4'($urandom_range(0, 15));
            tick(1);
        end
        row_valid_in = 1'b0;
        tick(250);
        // Sparse random valid.
        repeat (600) begin
            row_valid_in = ($urandom_range(0, 7) == 0);
            row_in = rand_row();
            row_address_in = 4'($urandom_range(0, 15));
            tick(1);
        end
        row_valid_in = 1'b0;
        tick(250);
        // Reset asserted between clock edges in the middle of SHIFT.
        send(rand_row(), 4'd2);
        tick(15);
        @(posedge clk_in);
        #2 n_reset_in = 1'b0;
        tick(2);
        n_reset_in = 1'b1;
        tick(1);
        send(pat_a, 4'd5);
        tick(250);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
